fp32_mul_seq: RTL



---
 rtl/fp32_pkg.sv | 33 +++
 rtl/fp32_mul_seq_if.sv | 21 ++
 rtl/adder25.sv | 18 +
 rtl/fp32_mul_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared types and constants for the sequential binary32 multiplier.
// Flag indices match the bit positions of flags_o = {invalid, overflow, underflow, inexact}.
package fp32_pkg;

  localparam int MANT_W  = 24;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MULT,
    S_NORM,
    S_ROUND
  } fsm_e;

  typedef enum logic [1:0] {
    FLAG_INEXACT   = 2'd0,
    FLAG_UNDERFLOW = 2'd1,
    FLAG_OVERFLOW  = 2'd2,
    FLAG_INVALID   = 2'd3
  } flag_idx_e;

endpackage

// File: rtl/fp32_mul_seq_if.sv
// Request/response bundle of the sequential multiplier.
// The master drives operands and start; the slave returns ready, result and flags.
interface fp32_mul_seq_if;
  logic        start;
  logic        in_ready;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        out_valid;
  logic [31:0] result_o;
  logic [3:0]  flags_o;

  modport master (
    output start, a_i, b_i,
    input  in_ready, out_valid, result_o, flags_o
  );

  modport slave (
    input  start, a_i, b_i,
    output in_ready, out_valid, result_o, flags_o
  );
endinterface

// File: rtl/adder25.sv
// 25-bit ripple-carry adder used as the partial-product accumulator.
// The carry out of the top bit is dropped: the accumulator never exceeds 25 bits.
module adder25 (
  input  logic [24:0] a,
  input  logic [24:0] b,
  input  logic        cin,
  output logic [24:0] sum
);
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < 25; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  end
endmodule

// File: rtl/fp32_mul_seq.sv
// Iterative binary32 multiplier: shift-and-add significand product, one bit per cycle,
// then normalise, round-to-nearest-even and pack. Subnormals flush to zero.
module fp32_mul_seq
  import fp32_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fp32_mul_seq_if.slave  bus
);
  localparam logic [4:0] CNT_LAST = 5'(MANT_W - 1);

  fsm_e               state_reg, state_next;
  fp32_t              a_reg, b_reg;
  logic [48:0]        p_reg;
  logic [4:0]         cnt_reg;
  logic signed [9:0]  exp_reg;
  logic               sign_reg;
  logic               special_reg;
  logic [31:0]        special_res_reg;
  logic [3:0]         special_flags_reg;
  logic [22:0]        mant_reg;
  logic               guard_reg, sticky_reg;
  logic               out_valid_reg;
  logic [31:0]        result_reg;
  logic [3:0]         flags_reg;

  logic [23:0]        mant_a;
  logic [24:0]        acc_sum;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_next;
  logic               special_next;
  logic [31:0]        special_res_next;
  logic [3:0]         special_flags_next;
  logic               round_up;
  logic [23:0]        mant_rnd;
  logic signed [9:0]  exp_rnd;
  logic [31:0]        result_next;
  logic [3:0]         flags_next;

  assign mant_a = {|a_reg.exp, a_reg.frac};

  adder25 u_acc (
    .a   (p_reg[48:24]),
    .b   ({1'b0, mant_a}),
    .cin (1'b0),
    .sum (acc_sum)
  );

  always_comb begin
    a_zero    = (a_reg.exp == 8'h00);
    b_zero    = (b_reg.exp == 8'h00);
    a_inf     = (a_reg.exp == 8'hFF) && (a_reg.frac == '0);
    b_inf     = (b_reg.exp == 8'hFF) && (b_reg.frac == '0);
    a_nan     = (a_reg.exp == 8'hFF) && (a_reg.frac != '0);
    b_nan     = (b_reg.exp == 8'hFF) && (b_reg.frac != '0);
    sign_next = a_reg.sign ^ b_reg.sign;

    special_next       = 1'b1;
    special_res_next   = {sign_next, 31'b0};
    special_flags_next = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      special_res_next                 = QNAN;
      special_flags_next[FLAG_INVALID] = 1'b1;
    end else if (a_inf || b_inf) begin
      special_res_next = POS_INF | {sign_next, 31'b0};
    end else if (!(a_zero || b_zero)) begin
      special_next = 1'b0;
    end
  end

  // A carry out of the rounded mantissa leaves its low 23 bits at zero, so only E moves.
  always_comb begin
    round_up = guard_reg & (sticky_reg | mant_reg[0]);
    mant_rnd = {1'b0, mant_reg} + 24'(round_up);
    exp_rnd  = exp_reg + 10'(mant_rnd[23]);

    result_next = {sign_reg, exp_rnd[7:0], mant_rnd[22:0]};
    flags_next  = '0;
    if (special_reg) begin
      result_next = special_res_reg;
      flags_next  = special_flags_reg;
    end else if (exp_rnd >= $signed(10'(EXP_MAX))) begin
      result_next                = POS_INF | {sign_reg, 31'b0};
      flags_next[FLAG_OVERFLOW]  = 1'b1;
      flags_next[FLAG_INEXACT]   = 1'b1;
    end else if (exp_rnd <= 10'sd0) begin
      result_next                = {sign_reg, 31'b0};
      flags_next[FLAG_UNDERFLOW] = 1'b1;
      flags_next[FLAG_INEXACT]   = 1'b1;
    end else begin
      flags_next[FLAG_INEXACT]   = guard_reg | sticky_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.start) state_next = S_UNPACK;
      S_UNPACK: state_next = S_MULT;
      S_MULT:   if (cnt_reg == CNT_LAST) state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg             <= '0;
      b_reg             <= '0;
      p_reg             <= '0;
      cnt_reg           <= '0;
      exp_reg           <= '0;
      sign_reg          <= 1'b0;
      special_reg       <= 1'b0;
      special_res_reg   <= '0;
      special_flags_reg <= '0;
      mant_reg          <= '0;
      guard_reg         <= 1'b0;
      sticky_reg        <= 1'b0;
      out_valid_reg     <= 1'b0;
      result_reg        <= '0;
      flags_reg         <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            a_reg <= bus.a_i;
            b_reg <= bus.b_i;
          end
        end
        S_UNPACK: begin
          sign_reg          <= sign_next;
          special_reg       <= special_next;
          special_res_reg   <= special_res_next;
          special_flags_reg <= special_flags_next;
          exp_reg           <= {2'b00, a_reg.exp} + {2'b00, b_reg.exp} - 10'(BIAS);
          p_reg             <= {25'b0, |b_reg.exp, b_reg.frac};
          cnt_reg           <= '0;
        end
        S_MULT: begin
          p_reg   <= p_reg[0] ? {1'b0, acc_sum, p_reg[23:1]} : {1'b0, p_reg[48:1]};
          cnt_reg <= cnt_reg + 5'd1;
        end
        S_NORM: begin
          if (p_reg[47]) begin
            mant_reg   <= p_reg[46:24];
            guard_reg  <= p_reg[23];
            sticky_reg <= |p_reg[22:0];
            exp_reg    <= exp_reg + 10'sd1;
          end else begin
            mant_reg   <= p_reg[45:23];
            guard_reg  <= p_reg[22];
            sticky_reg <= |p_reg[21:0];
          end
        end
        S_ROUND: begin
          result_reg    <= result_next;
          flags_reg     <= flags_next;
          out_valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.result_o  = result_reg;
  assign bus.flags_o   = flags_reg;
endmodule
